mux_sel_reg_nway: RTL and testbench

Parametrised successor to the ALU's fixed 16-bit 2:1 operand mux. Selects one of NCH WIDTH-bit source channels and registers the result into a single-entry output stage. Uses valid/ready handshakes on every input and on the output. Two grant modes: direct (select-driven) and round-robin. Sits between the operand sources (register file, immediate, forwarding paths) and the ALU input registers.

---
 rtl/mux_sel_reg_nway.sv | 73 +++++++
 tb/tb_mux_sel_reg_nway.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mux_sel_reg_nway.sv
// mux_sel_reg_nway: N-way valid/ready operand mux (direct or round-robin grant) into a one-entry output register
module mux_sel_reg_nway #(
    parameter int WIDTH = 16,
    parameter int NCH   = 4,
    parameter int SELW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    input  logic [SELW-1:0]      sel,
    input  logic                 mode,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SELW-1:0]      out_chan
);
    localparam int NPAD = 1 << SELW;
    typedef logic [SELW-1:0] idx_t;

    function automatic idx_t wrap_idx(input int v);
        return idx_t'(v % NCH);
    endfunction

    logic [NPAD-1:0] valid_pad;
    idx_t            rr_ptr;
    idx_t            rr_grant;
    idx_t            grant;
    idx_t            rr_next;
    logic            rr_found;
    logic            granted;
    logic            can_load;
    logic            load;

    // Indices past NCH-1 see a zero-padded valid bit, so an out-of-range sel never grants
    assign valid_pad = NPAD'(in_valid);
    assign can_load  = !out_valid || out_ready;

    always_comb begin
        rr_found = 1'b0;
        rr_grant = '0;
        for (int k = 0; k < NCH; k++) begin
            if (!rr_found && in_valid[wrap_idx(int'(rr_ptr) + k)]) begin
                rr_found = 1'b1;
                rr_grant = wrap_idx(int'(rr_ptr) + k);
            end
        end
    end

    assign granted  = mode ? rr_found : valid_pad[sel];
    assign grant    = mode ? rr_grant : sel;
    assign load     = rst_n && can_load && granted;
    assign in_ready = load ? (NCH'(1) << grant) : '0;
    assign rr_next  = (grant == idx_t'(NCH - 1)) ? '0 : grant + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_chan  <= '0;
            out_valid <= 1'b0;
            rr_ptr    <= '0;
        end else if (load) begin
            out_data  <= in_data[grant*WIDTH +: WIDTH];
            out_chan  <= grant;
            out_valid <= 1'b1;
            if (mode)
                rr_ptr <= rr_next;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mux_sel_reg_nway.sv
// tb_mux_sel_reg_nway: directed checks of a 4-channel and a 3-channel instance
module tb_mux_sel_reg_nway;
    logic        clk = 1'b0;
    int          n_checks = 0;
    int          n_fails = 0;

    logic        a_rst_n;
    logic [63:0] a_in_data;
    logic [3:0]  a_in_valid;
    logic [3:0]  a_in_ready;
    logic [1:0]  a_sel;
    logic        a_mode;
    logic [15:0] a_out_data;
    logic        a_out_valid;
    logic        a_out_ready;
    logic [1:0]  a_out_chan;

    logic        b_rst_n;
    logic [23:0] b_in_data;
    logic [2:0]  b_in_valid;
    logic [2:0]  b_in_ready;
    logic [1:0]  b_sel;
    logic        b_mode;
    logic [7:0]  b_out_data;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [1:0]  b_out_chan;

    logic [15:0] a_ch [4];

    always #5 clk = ~clk;

    mux_sel_reg_nway #(.WIDTH(16), .NCH(4)) dut_a (
        .clk(clk), .rst_n(a_rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .sel(a_sel), .mode(a_mode), .out_data(a_out_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_chan(a_out_chan)
    );

    mux_sel_reg_nway #(.WIDTH(8), .NCH(3)) dut_b (
        .clk(clk), .rst_n(b_rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .sel(b_sel), .mode(b_mode), .out_data(b_out_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_chan(b_out_chan)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a_data();
        a_in_data = {a_ch[3], a_ch[2], a_ch[1], a_ch[0]};
    endtask

    initial begin
        a_ch[0] = 16'h1111; a_ch[1] = 16'h2222; a_ch[2] = 16'hA5A5; a_ch[3] = 16'h3333;
        set_a_data();
        a_rst_n = 1'b0; a_in_valid = 4'hF; a_sel = 2'd2; a_mode = 1'b0; a_out_ready = 1'b1;
        b_rst_n = 1'b0; b_in_data = {8'h33, 8'h22, 8'h11}; b_in_valid = 3'b111;
        b_sel = 2'd3; b_mode = 1'b0; b_out_ready = 1'b1;
        #2;
        chk("rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_out_data", 32'(a_out_data), 32'd0);
        chk("rst_in_ready", 32'(a_in_ready), 32'd0);
        tick();
        tick();
        chk("rst_hold_valid", 32'(a_out_valid), 32'd0);
        chk("rst_hold_ready", 32'(a_in_ready), 32'd0);
        chk("b_rst_in_ready", 32'(b_in_ready), 32'd0);
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        #1;
        chk("dir_in_ready_sel2", 32'(a_in_ready), 32'h4);
        tick();
        chk("dir_out_valid", 32'(a_out_valid), 32'd1);
        chk("dir_out_data", 32'(a_out_data), 32'hA5A5);
        chk("dir_out_chan", 32'(a_out_chan), 32'd2);

        a_sel = 2'd3; a_in_valid = 4'b0111;
        #1;
        chk("dir_nogrant_ready", 32'(a_in_ready), 32'd0);
        tick();
        chk("dir_drain_valid", 32'(a_out_valid), 32'd0);
        chk("dir_stale_data", 32'(a_out_data), 32'hA5A5);
        chk("dir_stale_chan", 32'(a_out_chan), 32'd2);

        a_mode = 1'b1; a_in_valid = 4'hF;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("rr_in_ready", 32'(a_in_ready), 32'(1 << (i % 4)));
            tick();
            chk("rr_out_chan", 32'(a_out_chan), 32'(i % 4));
            chk("rr_out_valid", 32'(a_out_valid), 32'd1);
            chk("rr_out_data", 32'(a_out_data), 32'(a_ch[i % 4]));
        end
        tick();
        chk("rr_chan2", 32'(a_out_chan), 32'd2);

        a_in_valid = 4'b0011;
        #1;
        chk("wrap_ready_ch0", 32'(a_in_ready), 32'h1);
        tick();
        chk("wrap_chan0", 32'(a_out_chan), 32'd0);
        chk("skip_ready_ch1", 32'(a_in_ready), 32'h2);
        tick();
        chk("skip_chan1", 32'(a_out_chan), 32'd1);
        chk("ptr2_ready_ch0", 32'(a_in_ready), 32'h1);

        a_out_ready = 1'b0; a_in_valid = 4'hF;
        for (int i = 0; i < 5; i++) begin
            a_sel = 2'(i); a_mode = i[0];
            #1;
            chk("stall_in_ready", 32'(a_in_ready), 32'd0);
            tick();
            chk("stall_valid", 32'(a_out_valid), 32'd1);
            chk("stall_data", 32'(a_out_data), 32'h2222);
            chk("stall_chan", 32'(a_out_chan), 32'd1);
        end
        a_mode = 1'b1; a_ch[1] = 16'hBEEF; set_a_data();
        a_out_ready = 1'b1; a_in_valid = 4'b0010;
        #1;
        chk("release_ready_ch1", 32'(a_in_ready), 32'h2);
        tick();
        chk("release_valid", 32'(a_out_valid), 32'd1);
        chk("release_data", 32'(a_out_data), 32'hBEEF);
        chk("release_chan", 32'(a_out_chan), 32'd1);

        a_mode = 1'b0; a_sel = 2'd0; a_in_valid = 4'hF;
        #1;
        chk("mode0_ready_ch0", 32'(a_in_ready), 32'h1);
        tick();
        chk("mode0_chan0", 32'(a_out_chan), 32'd0);
        a_mode = 1'b1;
        #1;
        chk("ptr_kept_ready_ch2", 32'(a_in_ready), 32'h4);
        tick();
        chk("ptr_kept_chan2", 32'(a_out_chan), 32'd2);

        for (int i = 0; i < 3; i++) begin
            chk("b_sel3_ready", 32'(b_in_ready), 32'd0);
            chk("b_sel3_valid", 32'(b_out_valid), 32'd0);
            tick();
        end
        b_mode = 1'b1;
        #1;
        chk("b_rr_ready_ch0", 32'(b_in_ready), 32'h1);
        tick();
        chk("b_rr_data0", 32'(b_out_data), 32'h11);
        tick();
        chk("b_rr_data1", 32'(b_out_data), 32'h22);
        b_out_ready = 1'b0;
        tick();
        chk("b_stall_valid", 32'(b_out_valid), 32'd1);
        chk("b_stall_chan", 32'(b_out_chan), 32'd1);
        #3;
        b_rst_n = 1'b0;
        #1;
        chk("b_async_valid", 32'(b_out_valid), 32'd0);
        chk("b_async_data", 32'(b_out_data), 32'd0);
        chk("b_async_ready", 32'(b_in_ready), 32'd0);
        tick();
        b_rst_n = 1'b1;
        #1;
        chk("b_ptr_reset_ready", 32'(b_in_ready), 32'h1);
        tick();
        chk("b_ptr_reset_chan", 32'(b_out_chan), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
